// File: rtl/y_result_writer.sv
`default_nettype none
// ============================================================================
// Module  : y_result_writer
// Brief   : Buffers finished y-vector results in a skid FIFO and issues them
//           as sequential 64-bit memory writes from a programmed base address.
//           Optional macro Y_RESULT_WRITER_IEEE_CONVERT_EN maps the exception
//           field to IEEE-754 words; otherwise the low 64 bits pass through.
// Revision: 1.0 - initial release
// ============================================================================
module y_result_writer #(
    parameter int FIFO_DEPTH      = 64,
    parameter int SKID            = 8,
    parameter int MAX_OUTSTANDING = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_to_y,
    input  logic [65:0] v_to_y,
    output logic        stall_out,
    input  logic        start,
    input  logic [47:0] y_base_addr,
    input  logic        eof,
    output logic        mem_req_valid,
    output logic [47:0] mem_req_addr,
    output logic [63:0] mem_req_data,
    input  logic        mem_req_stall,
    input  logic        mem_rsp_valid,
    output logic        done,
    output logic [31:0] written_count,
    output logic        overflow_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef logic [AW:0]   ptr_t;
    typedef logic [OW-1:0] out_t;

    localparam ptr_t STALL_LEVEL = ptr_t'(FIFO_DEPTH - SKID);
    localparam ptr_t FULL_LEVEL  = ptr_t'(FIFO_DEPTH);
    localparam out_t OUT_MAX     = out_t'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

`ifdef Y_RESULT_WRITER_IEEE_CONVERT_EN
    localparam int DW = 66;

    function automatic logic [63:0] to_word(input logic [DW-1:0] v);
        logic [63:0] w;
        case (v[65:64])
            2'b00:   w = {v[63], 63'b0};
            2'b01:   w = v[63:0];
            2'b10:   w = {v[63], 11'h7FF, 52'b0};
            default: w = 64'h7FF8_0000_0000_0000;
        endcase
        return w;
    endfunction
`else
    localparam int DW = 64;

    logic unused_exn;
    assign unused_exn = ^v_to_y[65:64];

    function automatic logic [63:0] to_word(input logic [DW-1:0] v);
        return v;
    endfunction
`endif

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] fifo_mem [FIFO_DEPTH];
    ptr_t          wr_ptr;
    ptr_t          rd_ptr;
    ptr_t          fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          active;
    logic          start_ok;
    logic          push_ok;
    logic          push_bad;
    logic          req_accept;
    logic          load;
    out_t          outstanding;
    out_t          outstanding_nxt;

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FULL_LEVEL);
    assign active     = (state == S_RUN) || (state == S_DRAIN);
    assign start_ok   = start && !active;
    assign push_ok    = push_to_y && active && !fifo_full;
    assign push_bad   = push_to_y && !push_ok;
    assign req_accept = mem_req_valid && !mem_req_stall;
    assign done       = (state == S_DONE);

    always_comb begin
        outstanding_nxt = outstanding;
        if (req_accept && !mem_rsp_valid) begin
            outstanding_nxt = outstanding + out_t'(1);
        end else if (!req_accept && mem_rsp_valid && (outstanding != '0)) begin
            outstanding_nxt = outstanding - out_t'(1);
        end
    end

    // A loaded entry will be accepted eventually, so it must fit under the cap
    // counted against the post-update outstanding value.
    assign load = !fifo_empty && (!mem_req_valid || req_accept) && (outstanding_nxt < OUT_MAX);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
            S_RUN:          if (eof) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (fifo_empty && !mem_req_valid && (outstanding == '0)) begin
                    state_nxt = S_DONE;
                end
            end
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr[AW-1:0]] <= v_to_y[DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            stall_out     <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
            written_count <= '0;
            outstanding   <= '0;
            overflow_err  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            stall_out <= (fifo_count >= STALL_LEVEL);

            if (load) begin
                mem_req_valid <= 1'b1;
                mem_req_data  <= to_word(fifo_mem[rd_ptr[AW-1:0]]);
            end else if (req_accept) begin
                mem_req_valid <= 1'b0;
            end

            if (start_ok) begin
                mem_req_addr  <= y_base_addr;
                written_count <= '0;
                outstanding   <= '0;
                overflow_err  <= 1'b0;
            end else begin
                if (req_accept) begin
                    mem_req_addr  <= mem_req_addr + 48'd8;
                    written_count <= written_count + 32'd1;
                end
                outstanding <= outstanding_nxt;
                if (push_bad) begin
                    overflow_err <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_y_result_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_y_result_writer
// Brief   : Self-checking bench for y_result_writer: vector table, directed
//           corner sequences and randomized runs against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_y_result_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push_to_y = 1'b0;
    logic [65:0] v_to_y = '0;
    logic        stall_out;
    logic        start = 1'b0;
    logic [47:0] y_base_addr = '0;
    logic        eof = 1'b0;
    logic        mem_req_valid;
    logic [47:0] mem_req_addr;
    logic [63:0] mem_req_data;
    logic        mem_req_stall = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic        done;
    logic [31:0] written_count;
    logic        overflow_err;

    always #5 clk = ~clk;

    y_result_writer dut (
        .clk          (clk),
        .rst          (rst),
        .push_to_y    (push_to_y),
        .v_to_y       (v_to_y),
        .stall_out    (stall_out),
        .start        (start),
        .y_base_addr  (y_base_addr),
        .eof          (eof),
        .mem_req_valid(mem_req_valid),
        .mem_req_addr (mem_req_addr),
        .mem_req_data (mem_req_data),
        .mem_req_stall(mem_req_stall),
        .mem_rsp_valid(mem_rsp_valid),
        .done         (done),
        .written_count(written_count),
        .overflow_err (overflow_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference conversion taken straight from the exception-field rules.
    function automatic logic [63:0] ref_conv(input logic [65:0] v);
`ifdef Y_RESULT_WRITER_IEEE_CONVERT_EN
        if (v[65:64] == 2'b00) return {v[63], 63'b0};
        if (v[65:64] == 2'b10) return {v[63], 11'h7FF, 52'b0};
        if (v[65:64] == 2'b11) return 64'h7FF8_0000_0000_0000;
        return v[63:0];
`else
        return v[63:0];
`endif
    endfunction

    typedef struct packed {
        logic [47:0] addr;
        logic [63:0] data;
    } req_t;

    req_t        exp_q[$];
    int          pending = 0;
    int          acc_count = 0;
    int          stall_mode = 0;
    bit          rsp_en = 1'b1;
    int          rsp_once_req = 0;
    int          rsp_once_done = 0;
    bit          held_v = 1'b0;
    logic [47:0] held_addr = '0;
    logic [63:0] held_data = '0;

    // Memory side: drives stall/response for the coming edge, then scores
    // whatever that edge will accept.
    always @(negedge clk) begin
        req_t e;
        if (rst) begin
            pending       = 0;
            held_v        = 1'b0;
            mem_rsp_valid = 1'b0;
            mem_req_stall = (stall_mode == 1);
        end else begin
            case (stall_mode)
                0:       mem_req_stall = 1'b0;
                1:       mem_req_stall = 1'b1;
                default: mem_req_stall = ($urandom_range(0, 3) == 0);
            endcase
            mem_rsp_valid = 1'b0;
            if (pending > 0 && ((rsp_en && $urandom_range(0, 1) == 1) || rsp_once_req > rsp_once_done)) begin
                mem_rsp_valid = 1'b1;
                pending--;
                if (rsp_once_req > rsp_once_done) rsp_once_done++;
            end
            if (held_v) begin
                check("held_valid", 64'(mem_req_valid), 64'd1);
                check("held_addr", 64'(mem_req_addr), 64'(held_addr));
                check("held_data", mem_req_data, held_data);
            end
            if (mem_req_valid && !mem_req_stall) begin
                if (exp_q.size() == 0) begin
                    check("spurious_req", 64'(mem_req_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("req_addr", 64'(mem_req_addr), 64'(e.addr));
                    check("req_data", mem_req_data, e.data);
                end
                pending++;
                acc_count++;
            end
            held_v    = mem_req_valid && mem_req_stall;
            held_addr = mem_req_addr;
            held_data = mem_req_data;
        end
    end

    logic [47:0] m_base = '0;
    int          m_idx = 0;
    bit          in_run = 1'b0;
    int          run_acc0 = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [47:0] b);
        start       = 1'b1;
        y_base_addr = b;
        m_base      = b;
        m_idx       = 0;
        in_run      = 1'b1;
        run_acc0    = acc_count;
        tick(1);
        start = 1'b0;
    endtask

    task automatic push_val(input logic [65:0] v, input logic [63:0] expd, input bit honor);
        int g;
        g = 0;
        if (honor) begin
            while (stall_out && g < 2000) begin
                tick(1);
                g++;
            end
            if (g == 2000) check("stall_wait", 64'(stall_out), 64'd0);
        end
        push_to_y = 1'b1;
        v_to_y    = v;
        if (in_run) begin
            exp_q.push_back('{m_base + 48'(m_idx * 8), expd});
            m_idx++;
        end
        tick(1);
        push_to_y = 1'b0;
    endtask

    task automatic end_run(input bit with_push, input logic [65:0] v, input logic [63:0] expd);
        int n;
        rsp_en = 1'b1;
        if (with_push) begin
            n = 0;
            while (stall_out && n < 2000) begin
                tick(1);
                n++;
            end
            eof = 1'b1;
            push_val(v, expd, 1'b0);
        end else begin
            eof = 1'b1;
            tick(1);
        end
        eof    = 1'b0;
        in_run = 1'b0;
        n      = 0;
        while (!done && n < 5000) begin
            tick(1);
            n++;
        end
        check("done", 64'(done), 64'd1);
        check("written_count", 64'(written_count), 64'(m_idx));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("no_overflow", 64'(overflow_err), 64'd0);
    endtask

    typedef struct {
        logic [65:0] v;
        logic [63:0] exp_ieee;
        logic [63:0] exp_raw;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [63:0] tbl_exp(input vec_t t);
`ifdef Y_RESULT_WRITER_IEEE_CONVERT_EN
        return t.exp_ieee;
`else
        return t.exp_raw;
`endif
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [65:0] v;
        logic [47:0] b;
        int          n;

        tbl[0] = '{{2'b01, 64'h3FF0_0000_0000_0000}, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000};
        tbl[1] = '{{2'b00, 64'h8123_4567_89AB_CDEF}, 64'h8000_0000_0000_0000, 64'h8123_4567_89AB_CDEF};
        tbl[2] = '{{2'b10, 64'h0000_0000_0000_1234}, 64'h7FF0_0000_0000_0000, 64'h0000_0000_0000_1234};
        tbl[3] = '{{2'b11, 64'h1111_2222_3333_4444}, 64'h7FF8_0000_0000_0000, 64'h1111_2222_3333_4444};
        tbl[4] = '{{2'b10, 64'hC000_0000_0000_0000}, 64'hFFF0_0000_0000_0000, 64'hC000_0000_0000_0000};
        tbl[5] = '{{2'b00, 64'h7FFF_FFFF_FFFF_FFFF}, 64'h0000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};

        // Reset values
        tick(3);
        check("rst_stall_out", 64'(stall_out), 64'd0);
        check("rst_valid", 64'(mem_req_valid), 64'd0);
        check("rst_addr", 64'(mem_req_addr), 64'd0);
        check("rst_data", mem_req_data, 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_count", 64'(written_count), 64'd0);
        check("rst_ovf", 64'(overflow_err), 64'd0);
        rst = 1'b0;
        tick(1);

        // Push while idle is dropped and flagged
        push_val({2'b01, 64'hDEAD_BEEF_0000_0001}, 64'd0, 1'b1);
        tick(3);
        check("idle_ovf", 64'(overflow_err), 64'd1);
        check("idle_no_req", 64'(mem_req_valid), 64'd0);
        check("idle_no_accept", 64'(acc_count), 64'd0);

        // Basic run with latency and done timing
        stall_mode = 0;
        do_start(48'h1000);
        check("start_clears_ovf", 64'(overflow_err), 64'd0);
        push_val({2'b01, 64'h3FF0_0000_0000_0000}, 64'h3FF0_0000_0000_0000, 1'b1);
        check("lat_n1", 64'(mem_req_valid), 64'd0);
        tick(1);
        check("lat_n2", 64'(mem_req_valid), 64'd1);
        for (int i = 1; i < 4; i++) begin
            v = {2'b01, 64'h4000_0000_0000_0000 + 64'(i * 8)};
            push_val(v, v[63:0], 1'b1);
        end
        n = 0;
        while ((exp_q.size() != 0 || pending != 0) && n < 500) begin
            tick(1);
            n++;
        end
        check("basic_acked", 64'(pending), 64'd0);
        tick(2);
        eof    = 1'b1;
        tick(1);
        eof    = 1'b0;
        in_run = 1'b0;
        check("done_e1", 64'(done), 64'd0);
        tick(1);
        check("done_e2", 64'(done), 64'd1);
        check("basic_count", 64'(written_count), 64'd4);
        tick(3);
        check("done_holds", 64'(done), 64'd1);

        // Conversion vector table
        stall_mode = 2;
        do_start(48'h8000);
        check("restart_clears_done", 64'(done), 64'd0);
        for (int i = 0; i < 6; i++) begin
            push_val(tbl[i].v, tbl_exp(tbl[i]), 1'b1);
        end
        end_run(1'b0, '0, '0);

        // Backpressure: memory stalled while 60 values arrive
        stall_mode = 1;
        do_start(48'h2000_0000);
        for (int i = 0; i < 55; i++) begin
            v = {2'b01, 64'(i) << 4};
            push_val(v, v[63:0], 1'b0);
        end
        tick(2);
        check("bp_stall_54", 64'(stall_out), 64'd0);
        v = {2'b01, 64'h0AAA};
        push_val(v, v[63:0], 1'b0);
        tick(2);
        check("bp_stall_55", 64'(stall_out), 64'd0);
        v = {2'b01, 64'h0BBB};
        push_val(v, v[63:0], 1'b0);
        check("bp_stall_n1", 64'(stall_out), 64'd0);
        tick(1);
        check("bp_stall_n2", 64'(stall_out), 64'd1);
        for (int i = 0; i < 3; i++) begin
            v = {2'b01, 64'h0CC0 + 64'(i)};
            push_val(v, v[63:0], 1'b0);
        end
        tick(30);
        check("bp_no_ovf", 64'(overflow_err), 64'd0);
        check("bp_none_accepted", 64'(acc_count - run_acc0), 64'd0);
        check("bp_held_valid", 64'(mem_req_valid), 64'd1);
        stall_mode = 2;
        end_run(1'b0, '0, '0);

        // Outstanding cap
        stall_mode = 0;
        rsp_en     = 1'b0;
        do_start(48'h10_0000);
        for (int i = 0; i < 260; i++) begin
            v = {2'b01, 64'h5000_0000 + 64'(i)};
            push_val(v, v[63:0], 1'b1);
        end
        tick(20);
        check("cap_issued", 64'(acc_count - run_acc0), 64'd255);
        check("cap_count", 64'(written_count), 64'd255);
        check("cap_idle_port", 64'(mem_req_valid), 64'd0);
        rsp_once_req++;
        tick(10);
        check("cap_one_more", 64'(acc_count - run_acc0), 64'd256);
        end_run(1'b0, '0, '0);

        // Address wrap at 2^48, final push in the eof cycle
        stall_mode = 2;
        do_start(48'hFFFF_FFFF_FFF8);
        v = {2'b01, 64'h1234_5678_9ABC_DEF0};
        push_val(v, ref_conv(v), 1'b1);
        v = {2'b01, 64'h0FED_CBA9_8765_4321};
        end_run(1'b1, v, ref_conv(v));

        // Randomized runs
        for (int r = 0; r < 4; r++) begin
            b      = {16'($urandom), $urandom};
            b[2:0] = 3'b000;
            do_start(b);
            n = $urandom_range(20, 80);
            for (int k = 0; k < n - 1; k++) begin
                v = {2'($urandom), $urandom, $urandom};
                push_val(v, ref_conv(v), 1'b1);
                tick($urandom_range(0, 2));
            end
            v = {2'($urandom), $urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                end_run(1'b1, v, ref_conv(v));
            end else begin
                push_val(v, ref_conv(v), 1'b1);
                end_run(1'b0, '0, '0);
            end
        end

        // Reset in DRAIN with queued values, then a fresh run
        stall_mode = 1;
        do_start(48'h3000);
        for (int i = 0; i < 3; i++) begin
            v = {2'b01, 64'h7777_0000 + 64'(i)};
            push_val(v, v[63:0], 1'b1);
        end
        eof = 1'b1;
        tick(1);
        eof = 1'b0;
        tick(2);
        check("pre_rst_valid", 64'(mem_req_valid), 64'd1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_valid", 64'(mem_req_valid), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_count", 64'(written_count), 64'd0);
        check("mid_rst_addr", 64'(mem_req_addr), 64'd0);
        rst        = 1'b0;
        stall_mode = 0;
        in_run     = 1'b0;
        exp_q.delete();
        tick(2);
        check("post_rst_idle_valid", 64'(mem_req_valid), 64'd0);
        do_start(48'h4000);
        v = {2'b01, 64'h1111_0000_0000_0001};
        push_val(v, v[63:0], 1'b1);
        v = {2'b01, 64'h1111_0000_0000_0002};
        push_val(v, v[63:0], 1'b1);
        end_run(1'b0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
